// File: rtl/mc_controller_pkg.sv
// Shared opcode/ALU encodings, FSM state type and instruction field helpers
// for the multi-cycle controller.
package mc_ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_MOV   = 4'b0010;
  localparam logic [3:0] OP_LOADI = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_JZ    = 4'b0110;
  localparam logic [3:0] OP_SHL   = 4'b0111;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_JMP   = 4'b1010;
  localparam logic [3:0] OP_JN    = 4'b1011;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_TEST = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_SHL  = 3'b100;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_IMM, S_RDA, S_LATCH,
    S_RDB, S_ALU, S_WB, S_BR, S_MEM, S_HALT
  } state_t;

  typedef enum logic [1:0] {BR_NONE, BR_ZERO, BR_NEG, BR_ALWAYS} br_cond_t;

  // Helpers work on a wide container so they serve any AW/RFA split.
  localparam int unsigned FW = 64;

  function automatic logic [FW-1:0] field_bits(input logic [FW-1:0] word,
                                               input int unsigned lsb,
                                               input int unsigned width);
    logic [FW-1:0] mask;
    mask = (FW'(1) << width) - FW'(1);
    return (word >> lsb) & mask;
  endfunction

  function automatic logic [3:0] opcode_of(input logic [FW-1:0] word, input int unsigned iw);
    return 4'(field_bits(word, iw - 4, 4));
  endfunction

  function automatic logic [FW-1:0] rd_of(input logic [FW-1:0] word,
                                          input int unsigned aw, input int unsigned rfa);
    return field_bits(word, aw, rfa);
  endfunction

  function automatic logic [FW-1:0] f_of(input logic [FW-1:0] word, input int unsigned aw);
    return field_bits(word, 0, aw);
  endfunction

  function automatic logic [FW-1:0] rs_of(input logic [FW-1:0] f,
                                          input int unsigned aw, input int unsigned rfa);
    return field_bits(f, aw - rfa, rfa);
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller-to-ROM/datapath bus; master is the controller side.
interface mc_controller_if #(
  parameter int AW  = 8,
  parameter int RFA = 4
);
  localparam int IW = 4 + RFA + AW;

  logic           start;
  logic [IW-1:0]  ir;
  logic           ir_valid;
  logic           alu_zero;
  logic           alu_neg;
  logic           ram_ready;
  logic           rom_en;
  logic [AW-1:0]  pc;
  logic           rf_en;
  logic           rf_we;
  logic [RFA-1:0] rf_sel;
  logic           reg_en;
  logic           alu_en;
  logic [2:0]     alu_op;
  logic           imm_en;
  logic [AW-1:0]  imm;
  logic           sel_mux;
  logic           ram_cs;
  logic           ram_wr;
  logic [AW-1:0]  ram_addr;
  logic           busy;
  logic           halted;
  logic           error;

  modport master (
    input  start, ir, ir_valid, alu_zero, alu_neg, ram_ready,
    output rom_en, pc, rf_en, rf_we, rf_sel, reg_en, alu_en, alu_op,
           imm_en, imm, sel_mux, ram_cs, ram_wr, ram_addr, busy, halted, error
  );

  modport slave (
    output start, ir, ir_valid, alu_zero, alu_neg, ram_ready,
    input  rom_en, pc, rf_en, rf_we, rf_sel, reg_en, alu_en, alu_op,
           imm_en, imm, sel_mux, ram_cs, ram_wr, ram_addr, busy, halted, error
  );
endinterface

// File: rtl/mc_controller_decode.sv
// Opcode decoder: first micro-state, ALU operation and branch condition
// for each instruction; flags opcodes outside the instruction set.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output state_t     first,
  output logic [2:0] alu_op,
  output br_cond_t   br_cond,
  output logic       legal
);

  always_comb begin
    first   = S_FETCH;
    alu_op  = ALU_PASS;
    br_cond = BR_NONE;
    legal   = 1'b1;
    case (opcode)
      OP_LOADI: first = S_IMM;
      OP_ADD:   begin first = S_RDA; alu_op = ALU_ADD; end
      OP_SUB:   begin first = S_RDA; alu_op = ALU_SUB; end
      OP_MOV:   first = S_RDA;
      OP_SHL:   begin first = S_IMM; alu_op = ALU_SHL; end
      OP_JZ:    begin first = S_RDB; alu_op = ALU_TEST; br_cond = BR_ZERO; end
      OP_JN:    begin first = S_RDB; alu_op = ALU_TEST; br_cond = BR_NEG; end
      OP_JMP:   begin first = S_BR;  br_cond = BR_ALWAYS; end
      OP_STORE: first = S_RDB;
      OP_NOP:   first = S_FETCH;
      OP_HALT:  first = S_HALT;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle fetch/decode/sequence controller for the simple processor.
// Define MC_ILLEGAL_TRAP_EN to halt with a sticky error on undefined opcodes.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int AW  = 8,
  parameter int RFA = 4
) (
  input logic             clk,
  input logic             rst,
  mc_controller_if.master bus
);

  localparam int IW = 4 + RFA + AW;

  state_t         state, state_nx;
  logic [3:0]     op_q;
  logic [RFA-1:0] rd_q;
  logic [AW-1:0]  f_q;
  logic [AW-1:0]  pc_q;
  logic [AW-1:0]  imm_q;
  logic [RFA-1:0] rs;

  state_t         dec_first;
  logic [2:0]     dec_alu_op;
  br_cond_t       dec_br;
  logic           dec_legal;
  logic           br_taken;

  mc_decode u_decode (
    .opcode  (op_q),
    .first   (dec_first),
    .alu_op  (dec_alu_op),
    .br_cond (dec_br),
    .legal   (dec_legal)
  );

  assign rs = RFA'(rs_of(FW'(f_q), AW, RFA));

  always_comb begin
    case (dec_br)
      BR_ZERO:   br_taken = bus.alu_zero;
      BR_NEG:    br_taken = bus.alu_neg;
      BR_ALWAYS: br_taken = 1'b1;
      default:   br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc_q  <= '0;
      imm_q <= '0;
      op_q  <= '0;
      rd_q  <= '0;
      f_q   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE:   pc_q <= '0;
        S_FETCH:  if (bus.ir_valid) begin
                    op_q <= opcode_of(FW'(bus.ir), IW);
                    rd_q <= RFA'(rd_of(FW'(bus.ir), AW, RFA));
                    f_q  <= AW'(f_of(FW'(bus.ir), AW));
                  end
        S_DECODE: pc_q <= pc_q + AW'(1);
        S_IMM:    imm_q <= f_q;
        S_BR:     if (br_taken) pc_q <= f_q;
        default:  ;
      endcase
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic error_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                error_q <= 1'b0;
    else if (state == S_DECODE && !dec_legal) error_q <= 1'b1;
  end
  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif

  assign bus.pc     = pc_q;
  assign bus.imm    = imm_q;
  assign bus.busy   = (state != S_IDLE) && (state != S_HALT);
  assign bus.halted = (state == S_HALT);

  // The micro-state successor depends on the latched opcode, so one state
  // (e.g. S_ALU) serves every instruction that passes through it.
  always_comb begin
    state_nx     = state;
    bus.rom_en   = 1'b0;
    bus.rf_en    = 1'b0;
    bus.rf_we    = 1'b0;
    bus.rf_sel   = '0;
    bus.reg_en   = 1'b0;
    bus.alu_en   = 1'b0;
    bus.alu_op   = ALU_PASS;
    bus.imm_en   = 1'b0;
    bus.sel_mux  = 1'b1;
    bus.ram_cs   = 1'b0;
    bus.ram_wr   = 1'b0;
    bus.ram_addr = '0;
    case (state)
      S_IDLE:   if (bus.start) state_nx = S_FETCH;
      S_FETCH: begin
        bus.rom_en = 1'b1;
        if (bus.ir_valid) state_nx = S_DECODE;
      end
      S_DECODE: begin
`ifdef MC_ILLEGAL_TRAP_EN
        state_nx = dec_legal ? dec_first : S_HALT;
`else
        state_nx = dec_first;
`endif
      end
      S_IMM: begin
        bus.imm_en = 1'b1;
        state_nx   = (op_q == OP_SHL) ? S_LATCH : S_ALU;
      end
      S_RDA: begin
        bus.rf_en  = 1'b1;
        bus.rf_sel = rs;
        state_nx   = (op_q == OP_ADD || op_q == OP_SUB) ? S_LATCH : S_ALU;
      end
      S_LATCH: begin
        bus.reg_en  = 1'b1;
        bus.sel_mux = (op_q != OP_SHL);
        state_nx    = S_RDB;
      end
      S_RDB: begin
        bus.rf_en  = 1'b1;
        bus.rf_sel = rd_q;
        state_nx   = S_ALU;
      end
      S_ALU: begin
        bus.alu_en  = 1'b1;
        bus.alu_op  = dec_alu_op;
        bus.sel_mux = (op_q != OP_LOADI);
        if (dec_br != BR_NONE)    state_nx = S_BR;
        else if (op_q == OP_STORE) state_nx = S_MEM;
        else                       state_nx = S_WB;
      end
      S_WB: begin
        bus.rf_en  = 1'b1;
        bus.rf_we  = 1'b1;
        bus.rf_sel = rd_q;
        state_nx   = S_FETCH;
      end
      S_BR:     state_nx = S_FETCH;
      S_MEM: begin
        bus.ram_cs   = 1'b1;
        bus.ram_wr   = 1'b1;
        bus.ram_addr = f_q;
        if (bus.ram_ready) state_nx = S_FETCH;
      end
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Randomized instruction-stream bench for mc_controller with a per-opcode
// micro-op recipe model; honours MC_ILLEGAL_TRAP_EN when defined.
module tb_mc_controller;

  localparam int AW  = 8;
  localparam int RFA = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_controller_if #(.AW(AW), .RFA(RFA)) bus ();
  mc_controller #(.AW(AW), .RFA(RFA)) dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0] m_pc, m_imm;
  logic       m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_vec(input logic rom, rfen, rfwe, input logic [3:0] sel,
                                           input logic regen, aluen, input logic [2:0] aop,
                                           input logic immen, smux, cs, wr, input logic [7:0] addr,
                                           input logic bsy, hlt, err);
    return {5'b0, rom, rfen, rfwe, sel, regen, aluen, aop, immen, smux, cs, wr, addr, bsy, hlt, err};
  endfunction

  // rf_sel/alu_op/ram_addr are only compared while their strobe is expected,
  // unless strict (reset values).
  task automatic expect_cycle(input string tag, input logic rom, rfen, rfwe, input logic [3:0] sel,
                              input logic regen, aluen, input logic [2:0] aop, input logic immen,
                              smux, cs, input logic [7:0] addr, input logic bsy, hlt,
                              input bit strict);
    logic [31:0] act, exp;
    act = pack_vec(bus.rom_en, bus.rf_en, bus.rf_we, (strict || rfen) ? bus.rf_sel : 4'h0,
                   bus.reg_en, bus.alu_en, (strict || aluen) ? bus.alu_op : 3'h0,
                   bus.imm_en, bus.sel_mux, bus.ram_cs, bus.ram_wr,
                   (strict || cs) ? bus.ram_addr : 8'h0, bus.busy, bus.halted, bus.error);
    exp = pack_vec(rom, rfen, rfwe, sel, regen, aluen, aop, immen, smux, cs, cs, addr,
                   bsy, hlt, m_err);
    check(tag, act, exp);
    check({tag, ".pc"}, 32'(bus.pc), 32'(m_pc));
    check({tag, ".imm"}, 32'(bus.imm), 32'(m_imm));
  endtask

  task automatic idle_check(input string tag, input bit strict);
    expect_cycle(tag, 0, 0, 0, 4'h0, 0, 0, 3'h0, 0, 1, 0, 8'h00, 0, 0, strict);
  endtask

  task automatic halt_check(input string tag);
    expect_cycle(tag, 0, 0, 0, 4'h0, 0, 0, 3'h0, 0, 1, 0, 8'h00, 0, 1, 0);
  endtask

  task automatic start_from_idle();
    idle_check("idle", 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    m_pc = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    #1;
    m_pc = 8'h00; m_imm = 8'h00; m_err = 1'b0;
    idle_check("reset", 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Micro-op recipe per opcode: i=IMM a=RDA l=LATCH b=RDB x=ALU w=WB j=BR m=MEM
  function automatic string recipe(input logic [3:0] op, output logic [2:0] aop);
    aop = 3'b000;
    case (op)
      4'b0011: return "ixw";
      4'b0100: begin aop = 3'b010; return "albxw"; end
      4'b0101: begin aop = 3'b011; return "albxw"; end
      4'b0010: return "axw";
      4'b0111: begin aop = 3'b100; return "ilbxw"; end
      4'b0110: begin aop = 3'b001; return "bxj"; end
      4'b1011: begin aop = 3'b001; return "bxj"; end
      4'b1010: return "j";
      4'b1000: return "bxm";
      default: return "";
    endcase
  endfunction

  task automatic run_instr(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] f,
                           input int rom_wait, input int ram_wait, input logic z, input logic n,
                           input int abort_at, output bit aborted);
    string s;
    logic [2:0] aop;
    logic [3:0] rs;
    bit taken;
    aborted = 0;
    rs = f[7:4];
    for (int i = 0; i <= rom_wait; i++) begin
      expect_cycle("fetch", 1, 0, 0, 4'h0, 0, 0, 3'h0, 0, 1, 0, 8'h00, 1, 0, 0);
      bus.start    = 1'($urandom_range(0, 1));
      bus.ir_valid = (i == rom_wait);
      bus.ir       = (i == rom_wait) ? {op, rd, f} : 16'($urandom);
      @(negedge clk);
    end
    bus.ir_valid = 1'b0;
    bus.ir       = 16'($urandom);
    expect_cycle("decode", 0, 0, 0, 4'h0, 0, 0, 3'h0, 0, 1, 0, 8'h00, 1, 0, 0);
    m_pc = m_pc + 8'h01;
    @(negedge clk);
    s = recipe(op, aop);
    for (int i = 0; i < s.len(); i++) begin
      if (i == abort_at) begin
        aborted = 1;
        return;
      end
      bus.start = 1'($urandom_range(0, 1));
      case (s[i])
        "i": begin
          expect_cycle("imm", 0, 0, 0, 4'h0, 0, 0, 3'h0, 1, 1, 0, 8'h00, 1, 0, 0);
          m_imm = f;
        end
        "a": expect_cycle("rda", 0, 1, 0, rs, 0, 0, 3'h0, 0, 1, 0, 8'h00, 1, 0, 0);
        "l": expect_cycle("latch", 0, 0, 0, 4'h0, 1, 0, 3'h0, 0, op != 4'b0111, 0, 8'h00, 1, 0, 0);
        "b": expect_cycle("rdb", 0, 1, 0, rd, 0, 0, 3'h0, 0, 1, 0, 8'h00, 1, 0, 0);
        "x": expect_cycle("alu", 0, 0, 0, 4'h0, 0, 1, aop, 0, op != 4'b0011, 0, 8'h00, 1, 0, 0);
        "w": expect_cycle("wb", 0, 1, 1, rd, 0, 0, 3'h0, 0, 1, 0, 8'h00, 1, 0, 0);
        "j": begin
          bus.alu_zero = z;
          bus.alu_neg  = n;
          expect_cycle("br", 0, 0, 0, 4'h0, 0, 0, 3'h0, 0, 1, 0, 8'h00, 1, 0, 0);
          taken = (op == 4'b1010) || (op == 4'b0110 && z) || (op == 4'b1011 && n);
          if (taken) m_pc = f;
        end
        "m": begin
          for (int k = 0; k < ram_wait; k++) begin
            bus.ram_ready = 1'b0;
            expect_cycle("mem", 0, 0, 0, 4'h0, 0, 0, 3'h0, 0, 1, 1, f, 1, 0, 0);
            @(negedge clk);
          end
          bus.ram_ready = 1'b1;
          expect_cycle("mem", 0, 0, 0, 4'h0, 0, 0, 3'h0, 0, 1, 1, f, 1, 0, 0);
        end
        default: check("recipe", 32'(s[i]), 32'h0);
      endcase
      @(negedge clk);
      bus.ram_ready = 1'b0;
    end
  endtask

  logic [3:0] legal_ops [10] = '{4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                 4'b0110, 4'b0111, 4'b1000, 4'b1010, 4'b1011};

  initial begin
    bit ab;
    rst = 1'b1;
    bus.start = 1'b0; bus.ir = '0; bus.ir_valid = 1'b0;
    bus.alu_zero = 1'b0; bus.alu_neg = 1'b0; bus.ram_ready = 1'b0;
    m_pc = 8'h00; m_imm = 8'h00; m_err = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    idle_check("idle_hold", 0);
    @(negedge clk);
    start_from_idle();

    run_instr(4'b0011, 4'd3, 8'h5A, 0, 0, 0, 0, -1, ab);   // LOADI r3,0x5A
    run_instr(4'b0100, 4'd2, 8'h10, 0, 0, 0, 0, -1, ab);   // ADD r2 += r1
    run_instr(4'b0110, 4'd1, 8'h20, 0, 0, 1, 0, -1, ab);   // JZ taken
    run_instr(4'b0110, 4'd1, 8'h20, 0, 0, 0, 1, -1, ab);   // JZ not taken
    run_instr(4'b1011, 4'd4, 8'h40, 1, 0, 0, 1, -1, ab);   // JN taken
    run_instr(4'b1011, 4'd4, 8'h90, 0, 0, 1, 0, -1, ab);   // JN not taken
    run_instr(4'b1010, 4'd0, 8'hFF, 2, 0, 0, 0, -1, ab);   // JMP 0xFF
    run_instr(4'b0000, 4'd0, 8'h00, 0, 0, 0, 0, -1, ab);   // NOP at 0xFF, pc wraps
    run_instr(4'b1000, 4'd5, 8'h77, 0, 4, 0, 0, -1, ab);   // STORE, 4 wait cycles
    run_instr(4'b0111, 4'd6, 8'h03, 0, 0, 0, 0, -1, ab);   // SHL

    for (int t = 0; t < 150; t++) begin
      run_instr(legal_ops[$urandom_range(0, 9)], 4'($urandom), 8'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, ab);
    end

    run_instr(4'b1100, 4'd0, 8'h00, 0, 0, 0, 0, -1, ab);   // undefined opcode
`ifdef MC_ILLEGAL_TRAP_EN
    m_err = 1'b1;
    bus.start = 1'b1;
    halt_check("trap");
    @(negedge clk);
    halt_check("trap_sticky");
    do_reset();
    start_from_idle();
`else
    run_instr(4'b0011, 4'd7, 8'hC3, 0, 0, 0, 0, -1, ab);   // continues as after NOP
`endif

    // Reset during the third execute cycle (RDB) of an ADD
    run_instr(4'b0100, 4'd9, 8'hA0, 0, 0, 0, 0, 2, ab);
    check("abort_reached", 32'(ab), 32'd1);
    do_reset();
    start_from_idle();
    run_instr(4'b0011, 4'd1, 8'h33, 0, 0, 0, 0, -1, ab);

    run_instr(4'b1111, 4'd0, 8'h00, 0, 0, 0, 0, -1, ab);   // HALT
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      halt_check("halt");
      @(negedge clk);
    end
    do_reset();
    idle_check("post_halt", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Parametrised multi-cycle controller for the simple processor: fetches instructions from ROM, decodes them and sequences register-file, ALU, immediate and RAM strobes.
- Generalises the first-generation controller in several ways:
  - configurable PC/address and register-select widths;
  - ready/valid waits on ROM and RAM;
  - added JMP and JN instructions, a busy/halted status and optional illegal-opcode trapping.
- Sits between the instruction ROM and the datapath (register file, operand register, ALU, immediate mux, data RAM).

Parameters:
- AW, 8, PC / jump-target / RAM-address width; also the immediate field width.
- RFA, 4, register-select width (2**RFA registers); requires RFA <= AW.
- IW, 4+RFA+AW, instruction width; derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  level; sampled only in S_IDLE.
- ir  in  IW  instruction word: opcode ir[IW-1 -: 4], rd ir[AW+RFA-1 -: RFA], field f = ir[AW-1:0], rs = f[AW-1 -: RFA].
- ir_valid  in  1  ROM data valid.
- alu_zero  in  1  ALU result == 0.
- alu_neg  in  1  ALU result MSB.
- ram_ready  in  1  RAM write accepted.
- rom_en  out  1  ROM read request.
- pc  out  AW  program counter.
- rf_en  out  1  register-file access strobe.
- rf_we  out  1  1 = write, 0 = read.
- rf_sel  out  RFA  register select.
- reg_en  out  1  operand-register load strobe.
- alu_en  out  1  ALU evaluate strobe.
- alu_op  out  3  000 PASS, 001 TEST, 010 ADD, 011 SUB, 100 SHL.
- imm_en  out  1  immediate-register load strobe.
- imm  out  AW  immediate value.
- sel_mux  out  1  0 = immediate path, 1 = register-file path.
- ram_cs  out  1  RAM chip select.
- ram_wr  out  1  RAM write.
- ram_addr  out  AW  RAM address.
- busy  out  1  high in every state except S_IDLE and S_HALT.
- halted  out  1  high in S_HALT.
- error  out  1  illegal-opcode flag (see Optional Feature).

Behaviour:
- Reset: async, active-high. State = S_IDLE. All strobes = 0 and sel_mux = 1. pc, imm, rf_sel, ram_addr, alu_op and latched fields = 0. busy, halted and error = 0. Reset mid-instruction aborts with no RAM write completing.
- Strobes (rom_en, rf_en, rf_we, reg_en, alu_en, imm_en, ram_cs, ram_wr) default to 0 every cycle unless the current state asserts them. sel_mux defaults to 1.
- S_IDLE: pc <= 0. If start = 1, go to S_FETCH; otherwise stay.
- S_FETCH: rom_en = 1 and address = pc. Hold until ir_valid = 1; on that edge latch opcode/rd/f and go to S_DECODE.
- S_DECODE: pc <= pc+1, wrapping (2**AW)-1 to 0. Then branch by opcode:
  - 0011 LOADI: IMM, ALU(PASS), WB.
  - 0100 ADD: RDA, LATCH, RDB, ALU(ADD), WB.
  - 0101 SUB: RDA, LATCH, RDB, ALU(SUB), WB.
  - 0010 MOV: RDA, ALU(PASS), WB.
  - 0111 SHL: IMM, LATCH with sel_mux = 0, RDB, ALU(SHL), WB.
  - 0110 JZ: RDB, ALU(TEST), BR, taken if alu_zero.
  - 1011 JN: RDB, ALU(TEST), BR, taken if alu_neg.
  - 1010 JMP: BR, always taken.
  - 1000 STORE: RDB, ALU(PASS), MEM.
  - 0000 NOP: back to S_FETCH.
  - 1111 HALT: S_HALT.
  - Any other opcode: see Optional Feature.
- Micro-states (one cycle each unless stated):
  - IMM: imm <= f, imm_en = 1.
  - RDA: rf_en = 1, rf_we = 0, rf_sel = rs.
  - LATCH: reg_en = 1.
  - RDB: rf_en = 1, rf_we = 0, rf_sel = rd.
  - ALU: alu_en = 1 with the given alu_op. sel_mux = 0 for LOADI, otherwise 1.
  - WB: rf_en = 1, rf_we = 1, rf_sel = rd, then S_FETCH.
  - BR: if taken, pc <= f (overrides the increment from S_DECODE); then S_FETCH.
  - MEM: ram_cs = ram_wr = 1, ram_addr = f. Held until ram_ready = 1 is sampled, then S_FETCH. No timeout.
- S_HALT: absorbing; only rst exits.
- start is ignored while busy.
- Latency with zero-wait ROM: LOADI = 5 cycles fetch-to-fetch; ADD = 7; JMP = 3.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode sets error = 1 and goes to S_HALT. error is sticky until rst.
- Undefined: an undefined opcode executes as NOP, and error is tied to 0.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode constants;
  - alu_op constants;
  - the state enum;
  - the field-extraction helper functions.
- One sub-module, mc_decode: combinational map from opcode to the first micro-state plus the instruction's alu_op and branch condition. The main FSM stays in mc_controller.

Test Plan:
- rst pulse mid-ADD at cycle 3 of execute -> next cycle all strobes 0, pc = 0, state S_IDLE; start = 1 then refetches from 0.
- LOADI r3,0x5A with ir_valid immediate -> imm = 0x5A, imm_en in cycle 3, WB with rf_sel = 3 and rf_we = 1 in cycle 5, pc = 1.
- ADD r2 += r1 -> RDA rf_sel = 1, reg_en, RDB rf_sel = 2, alu_op = 010, WB rf_sel = 2; total 7 cycles.
- JZ with alu_zero = 1, f = 0x20 -> pc = 0x20. Same with alu_zero = 0 -> pc = old+1. JN likewise on alu_neg. Also check pc wrap at 0xFF -> 0x00.
- STORE with ram_ready held low for 4 cycles -> ram_cs/ram_wr/ram_addr stable for all 5 cycles, then S_FETCH.
- Opcode 1100 -> error = 1 and halted = 1 with MC_ILLEGAL_TRAP_EN; NOP and next fetch without it. HALT -> halted = 1, ignores start until rst.
